// File: rtl/soc_periph_arb_pkg.sv
// Shared types and SoC address map for the peripheral arbiter.
package soc_periph_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } arb_state_e;

    typedef enum logic [3:0] {
        PERIPH_DRAM  = 4'd0,
        PERIPH_GPIO  = 4'd1,
        PERIPH_ETH   = 4'd2,
        PERIPH_SPI   = 4'd3,
        PERIPH_TIMER = 4'd4,
        PERIPH_UART  = 4'd5,
        PERIPH_PLIC  = 4'd6,
        PERIPH_CLINT = 4'd7,
        PERIPH_ROM   = 4'd8,
        PERIPH_DEBUG = 4'd9
    } periph_e;

    localparam int unsigned NumPeriph = 10;

    // Indexed by periph_e value.
    localparam logic [63:0] PeriphBase [NumPeriph] = '{
        64'h0000_0000_8000_0000,
        64'h0000_0000_0010_0000,
        64'h0000_0000_3000_0000,
        64'h0000_0000_2000_0000,
        64'h0000_0000_1800_0000,
        64'h0000_0000_1000_0000,
        64'h0000_0000_0C00_0000,
        64'h0000_0000_0200_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_0000
    };

    localparam logic [63:0] PeriphLen [NumPeriph] = '{
        64'h0000_0000_4000_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0080_0000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_03FF_FFFF,
        64'h0000_0000_000C_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_1000
    };

endpackage

// File: rtl/soc_periph_addr_decode.sv
// Combinational SoC address decoder: maps an address to a peripheral index.
module soc_periph_addr_decode
    import soc_periph_arb_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    output periph_e              index_o,
    output logic                 hit_o
);

    localparam int unsigned ExtW = (AddrWidth > 64) ? AddrWidth : 64;

    logic [ExtW-1:0] addr_ext;
    logic [ExtW-1:0] offset;

    // Offset compare avoids computing base+length, which could wrap.
    always_comb begin
        addr_ext = ExtW'(addr_i);
        offset   = '0;
        index_o  = PERIPH_DRAM;
        hit_o    = 1'b0;
        for (int unsigned i = 0; i < NumPeriph; i++) begin
            offset = addr_ext - ExtW'(PeriphBase[i]);
            if (!hit_o && (addr_ext >= ExtW'(PeriphBase[i])) && (offset < ExtW'(PeriphLen[i]))) begin
                hit_o   = 1'b1;
                index_o = periph_e'(i[3:0]);
            end
        end
    end

endmodule

// File: rtl/soc_periph_arbiter.sv
// Round-robin N-master to single-slave peripheral arbiter with SoC address decode.
// Optional RESP watchdog enabled by defining SOC_PERIPH_ARB_TIMEOUT_EN.
module soc_periph_arbiter
    import soc_periph_arb_pkg::*;
#(
    parameter int unsigned NrMasters     = 2,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NrMasters-1:0]                 req_i,
    input  logic [NrMasters-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NrMasters-1:0]                 we_i,
    input  logic [NrMasters-1:0][DataWidth-1:0]  wdata_i,
    output logic [NrMasters-1:0]                 gnt_o,
    output logic [NrMasters-1:0]                 rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    output logic                                 err_o,
    output logic                                 slv_req_o,
    output logic [3:0]                           slv_sel_o,
    output logic [AddrWidth-1:0]                 slv_addr_o,
    output logic                                 slv_we_o,
    output logic [DataWidth-1:0]                 slv_wdata_o,
    input  logic                                 slv_gnt_i,
    input  logic                                 slv_rvalid_i,
    input  logic [DataWidth-1:0]                 slv_rdata_i,
    input  logic                                 slv_err_i
);

    localparam int unsigned IdxW = $clog2(NrMasters);

    if (NrMasters < 2 || TimeoutCycles < 1) begin : g_bad_params
        $error("soc_periph_arbiter: NrMasters must be >= 2 and TimeoutCycles >= 1");
    end

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [IdxW-1:0]      owner_q, owner_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    periph_e              sel_q, sel_d;

`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    logic            win_valid;
    logic [IdxW-1:0] win_idx;
    int unsigned     cand;
    periph_e         dec_idx;
    logic            dec_hit;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NrMasters; i++) begin
            cand = (32'(ptr_q) + i) % NrMasters;
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = IdxW'(cand);
            end
        end
    end

    soc_periph_addr_decode #(
        .AddrWidth (AddrWidth)
    ) u_decode (
        .addr_i  (addr_i[win_idx]),
        .index_o (dec_idx),
        .hit_o   (dec_hit)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        gnt_o     = '0;
        rvalid_o  = '0;
        rdata_o   = '0;
        err_o     = 1'b0;
        slv_req_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Grant is suppressed while reset is held so every output reads 0.
                if (win_valid && !rst_i) begin
                    gnt_o[win_idx] = 1'b1;
                    ptr_d   = (32'(win_idx) == NrMasters - 1) ? '0 : win_idx + 1'b1;
                    owner_d = win_idx;
                    addr_d  = addr_i[win_idx];
                    we_d    = we_i[win_idx];
                    wdata_d = wdata_i[win_idx];
                    sel_d   = dec_hit ? dec_idx : PERIPH_DRAM;
                    state_d = dec_hit ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                slv_req_o = 1'b1;
                if (slv_gnt_i) begin
                    state_d = ST_RESP;
`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RESP: begin
                if (slv_rvalid_i) begin
                    rvalid_o[owner_q] = 1'b1;
                    rdata_o           = slv_rdata_i;
                    err_o             = slv_err_i;
                    state_d           = ST_IDLE;
                end
`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles)) begin
                    rvalid_o[owner_q] = 1'b1;
                    err_o             = 1'b1;
                    state_d           = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_ERR: begin
                rvalid_o[owner_q] = 1'b1;
                err_o             = 1'b1;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            sel_q   <= PERIPH_DRAM;
`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign slv_sel_o   = sel_q;
    assign slv_addr_o  = addr_q;
    assign slv_we_o    = we_q;
    assign slv_wdata_o = wdata_q;

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Bench for soc_periph_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_soc_periph_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;
`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // SoC map indexed by expected slv_sel_o value.
    localparam logic [63:0] BASE [10] = '{64'h8000_0000, 64'h0010_0000, 64'h3000_0000, 64'h2000_0000,
                                         64'h1800_0000, 64'h1000_0000, 64'h0C00_0000, 64'h0200_0000,
                                         64'h0001_0000, 64'h0000_0000};
    localparam logic [63:0] LEN  [10] = '{64'h4000_0000, 64'h0001_0000, 64'h0001_0000, 64'h0080_0000,
                                         64'h0000_1000, 64'h0000_1000, 64'h03FF_FFFF, 64'h000C_0000,
                                         64'h0001_0000, 64'h0000_1000};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_i = '0;
    logic [1:0][63:0] addr_i = '0;
    logic [1:0]       we_i = '0;
    logic [1:0][63:0] wdata_i = '0;
    logic [1:0]       gnt_o, rvalid_o;
    logic [63:0]      rdata_o;
    logic             err_o;
    logic             slv_req_o;
    logic [3:0]       slv_sel_o;
    logic [63:0]      slv_addr_o;
    logic             slv_we_o;
    logic [63:0]      slv_wdata_o;
    logic             slv_gnt_i = 1'b0;
    logic             slv_rvalid_i = 1'b0;
    logic [63:0]      slv_rdata_i = '0;
    logic             slv_err_i = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    soc_periph_arbiter #(
        .NrMasters     (N),
        .AddrWidth     (64),
        .DataWidth     (64),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req_i),
        .addr_i       (addr_i),
        .we_i         (we_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .slv_req_o    (slv_req_o),
        .slv_sel_o    (slv_sel_o),
        .slv_addr_o   (slv_addr_o),
        .slv_we_o     (slv_we_o),
        .slv_wdata_o  (slv_wdata_o),
        .slv_gnt_i    (slv_gnt_i),
        .slv_rvalid_i (slv_rvalid_i),
        .slv_rdata_i  (slv_rdata_i),
        .slv_err_i    (slv_err_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: one outstanding transaction record plus a round-robin pointer.
    bit          m_busy = 1'b0, m_acc = 1'b0, m_mapped = 1'b0, m_we = 1'b0;
    int          m_owner = 0, m_ptr = 0, m_wait = 0, m_sel = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;

    function automatic int pick(input logic [1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int decode(input logic [63:0] a);
        logic [64:0] x, lo, hi;
        x = {1'b0, a};
        for (int k = 0; k < 10; k++) begin
            lo = {1'b0, BASE[k]};
            hi = lo + {1'b0, LEN[k]};
            if (x >= lo && x < hi) return k;
        end
        return -1;
    endfunction

    function automatic int win();
        return pick(req_i, m_ptr);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_acc <= 1'b0; m_mapped <= 1'b0; m_we <= 1'b0;
            m_owner <= 0; m_ptr <= 0; m_wait <= 0; m_sel <= 0;
            m_addr <= '0; m_wdata <= '0;
        end else if (!m_busy) begin
            if (win() >= 0) begin
                m_busy   <= 1'b1;
                m_acc    <= 1'b0;
                m_wait   <= 0;
                m_owner  <= win();
                m_addr   <= addr_i[win()];
                m_we     <= we_i[win()];
                m_wdata  <= wdata_i[win()];
                m_mapped <= decode(addr_i[win()]) >= 0;
                m_sel    <= (decode(addr_i[win()]) >= 0) ? decode(addr_i[win()]) : 0;
                m_ptr    <= (win() + 1) % N;
            end
        end else if (!m_mapped) begin
            m_busy <= 1'b0;
        end else if (!m_acc) begin
            if (slv_gnt_i) begin
                m_acc  <= 1'b1;
                m_wait <= 0;
            end
        end else if (slv_rvalid_i) begin
            m_busy <= 1'b0;
        end else if (TO_EN && m_wait == TO) begin
            m_busy <= 1'b0;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0]  eg, erv;
        logic [63:0] erd;
        logic        eerr;
        eg = '0; erv = '0; erd = '0; eerr = 1'b0;
        if (!rst && !m_busy && win() >= 0) eg[win()] = 1'b1;
        if (!rst && m_busy) begin
            if (!m_mapped) begin
                erv[m_owner] = 1'b1; eerr = 1'b1;
            end else if (m_acc && slv_rvalid_i) begin
                erv[m_owner] = 1'b1; erd = slv_rdata_i; eerr = slv_err_i;
            end else if (m_acc && TO_EN && m_wait == TO) begin
                erv[m_owner] = 1'b1; eerr = 1'b1;
            end
        end
        chk("m_gnt", 64'(gnt_o), 64'(eg));
        chk("m_slv_req", 64'(slv_req_o), 64'(!rst && m_busy && m_mapped && !m_acc));
        chk("m_sel", 64'(slv_sel_o), 64'(m_sel));
        chk("m_addr", slv_addr_o, m_addr);
        chk("m_we", 64'(slv_we_o), 64'(m_we));
        chk("m_wdata", slv_wdata_o, m_wdata);
        chk("m_rvalid", 64'(rvalid_o), 64'(erv));
        if (erv != 2'b00 || rst) begin
            chk("m_rdata", rdata_o, erd);
            chk("m_err", 64'(err_o), 64'(eerr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // esel < 0 means the address must be rejected as unmapped.
    task automatic run_txn(input int m, input logic [63:0] a, input logic wr, input logic [63:0] wd,
                           input int gdly, input logic [63:0] rd, input logic serr, input int esel);
        logic [1:0] oh;
        oh = 2'b00;
        oh[m] = 1'b1;
        req_i = 2'b00;
        req_i[m] = 1'b1;
        addr_i[m] = a;
        we_i[m] = wr;
        wdata_i[m] = wd;
        @(negedge clk);
        chk("t_gnt", 64'(gnt_o), 64'(oh));
        chk("t_idle_no_req", 64'(slv_req_o), 64'd0);
        tick();
        req_i = 2'b00;
        @(negedge clk);
        if (esel < 0) begin
            chk("t_err_no_req", 64'(slv_req_o), 64'd0);
            chk("t_err_gnt", 64'(gnt_o), 64'd0);
            chk("t_err_rvalid", 64'(rvalid_o), 64'(oh));
            chk("t_err_err", 64'(err_o), 64'd1);
            chk("t_err_rdata", rdata_o, 64'd0);
            tick();
            return;
        end
        chk("t_slv_req", 64'(slv_req_o), 64'd1);
        chk("t_sel", 64'(slv_sel_o), 64'(esel));
        chk("t_addr", slv_addr_o, a);
        chk("t_we", 64'(slv_we_o), 64'(wr));
        chk("t_wdata", slv_wdata_o, wd);
        for (int k = 0; k < gdly; k++) begin
            tick();
            @(negedge clk);
            chk("t_req_hold", 64'(slv_req_o), 64'd1);
            chk("t_sel_hold", 64'(slv_sel_o), 64'(esel));
        end
        slv_gnt_i = 1'b1;
        tick();
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = rd;
        slv_err_i    = serr;
        @(negedge clk);
        chk("t_rvalid", 64'(rvalid_o), 64'(oh));
        chk("t_rdata", rdata_o, rd);
        chk("t_rerr", 64'(err_o), 64'(serr));
        tick();
        slv_rvalid_i = 1'b0;
        slv_rdata_i  = '0;
        slv_err_i    = 1'b0;
    endtask

    initial begin
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset holds grants low even with requests present.
        tick();
        tick();
        req_i = 2'b11;
        @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_slv_req", 64'(slv_req_o), 64'd0);
        chk("rst_addr", slv_addr_o, 64'd0);
        tick();
        req_i = 2'b00;
        rst   = 1'b0;
        tick();

        run_txn(0, 64'h1000_0004, 1'b0, 64'h0, 2, 64'hDEAD, 1'b0, 5);
        run_txn(1, 64'h4000_0000, 1'b0, 64'h0, 0, 64'h0, 1'b0, -1);
        run_txn(0, 64'hBFFF_FFFF, 1'b0, 64'h0, 0, 64'h11, 1'b0, 0);
        run_txn(1, 64'h8000_0000, 1'b1, 64'hCAFE, 1, 64'h0, 1'b0, 0);
        run_txn(0, 64'hC000_0000, 1'b0, 64'h0, 0, 64'h0, 1'b0, -1);
        run_txn(1, 64'h0010_0008, 1'b1, 64'h1234, 0, 64'h0, 1'b1, 1);
        run_txn(0, 64'h0000_0000, 1'b0, 64'h0, 0, 64'h77, 1'b0, 9);
        run_txn(1, 64'h0000_1000, 1'b0, 64'h0, 0, 64'h0, 1'b0, -1);
        run_txn(0, 64'h0FFF_FFFE, 1'b0, 64'h0, 0, 64'h66, 1'b0, 6);
        run_txn(1, 64'h0FFF_FFFF, 1'b0, 64'h0, 0, 64'h0, 1'b0, -1);
        run_txn(0, 64'h1_8000_0000, 1'b0, 64'h0, 0, 64'h0, 1'b0, -1);
        run_txn(1, 64'h0001_0000, 1'b0, 64'h0, 0, 64'h88, 1'b0, 8);

        // Master 0 wins (pointer moves to 1), then reset lands in RESP.
        req_i = 2'b01;
        addr_i[0] = 64'h1000_0000;
        we_i = 2'b00;
        tick();
        req_i = 2'b00;
        slv_gnt_i = 1'b1;
        tick();
        slv_gnt_i    = 1'b0;
        rst          = 1'b1;
        slv_rvalid_i = 1'b1;
        slv_rdata_i  = 64'hBEEF;
        @(negedge clk);
        chk("mid_gnt", 64'(gnt_o), 64'd0);
        chk("mid_rvalid", 64'(rvalid_o), 64'd0);
        chk("mid_rdata", rdata_o, 64'd0);
        chk("mid_err", 64'(err_o), 64'd0);
        chk("mid_slv_req", 64'(slv_req_o), 64'd0);
        chk("mid_sel", 64'(slv_sel_o), 64'd0);
        chk("mid_addr", slv_addr_o, 64'd0);
        chk("mid_we", 64'(slv_we_o), 64'd0);
        chk("mid_wdata", slv_wdata_o, 64'd0);

        // Contention from reset: slave always ready, grants must alternate from master 0.
        tick();
        req_i     = 2'b11;
        addr_i[0] = 64'h8000_0000;
        addr_i[1] = 64'h8000_1000;
        slv_gnt_i = 1'b1;
        slv_rdata_i = 64'h55;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_gnt", 64'(gnt_o), 64'(seq[k]));
            chk("cont_idle_rvalid", 64'(rvalid_o), 64'd0);
            tick();
            @(negedge clk);
            chk("cont_req_gnt", 64'(gnt_o), 64'd0);
            chk("cont_slv_req", 64'(slv_req_o), 64'd1);
            tick();
            @(negedge clk);
            chk("cont_rvalid", 64'(rvalid_o), 64'(seq[k]));
            chk("cont_rdata", rdata_o, 64'h55);
            tick();
        end
        req_i        = 2'b00;
        slv_gnt_i    = 1'b0;
        slv_rvalid_i = 1'b0;
        slv_rdata_i  = '0;
        tick();
        tick();

`ifdef SOC_PERIPH_ARB_TIMEOUT_EN
        req_i = 2'b01;
        addr_i[0] = 64'h1000_0008;
        tick();
        req_i = 2'b00;
        slv_gnt_i = 1'b1;
        tick();
        slv_gnt_i = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        chk("to_early", 64'(rvalid_o), 64'd0);
        tick();
        @(negedge clk);
        chk("to_rvalid", 64'(rvalid_o), 64'd1);
        chk("to_err", 64'(err_o), 64'd1);
        tick();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
